layer_sequencer: RTL and testbench

LAYER_SEQUENCER -- requirements
Module: layer_sequencer

---
 rtl/layer_sequencer_if.sv | 23 ++
 rtl/layer_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_layer_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/layer_sequencer_if.sv
// Tile-request channel between the layer sequencer (master) and the compute engine (slave).
interface layer_sequencer_if #(
   parameter int ADDR_W = 22
);
   logic              tile_valid;
   logic              tile_ready;
   logic [ADDR_W-1:0] tile_rd_addr;
   logic [ADDR_W-1:0] tile_wr_addr;
   logic [10:0]       tile_filter_base;
   logic [8:0]        tile_row;
   logic              tile_last;
   logic              tile_done;

   modport master (
      output tile_valid, tile_rd_addr, tile_wr_addr, tile_filter_base, tile_row, tile_last,
      input  tile_ready, tile_done
   );

   modport slave (
      input  tile_valid, tile_rd_addr, tile_wr_addr, tile_filter_base, tile_row, tile_last,
      output tile_ready, tile_done
   );
endinterface

// File: rtl/layer_sequencer.sv
// Layer sequencer: walks filter groups x output rows, issuing one tile request per row to the engine.
// Tile fields hold while tile_valid waits on tile_ready; done_layer follows the final tile_done by 2 cycles.
// Optional LAYER_SEQ_CYCLE_CNT_EN adds a 32-bit busy-cycle counter output (cycle_count).
module layer_sequencer #(
   parameter  int NUM_PE       = 16,
   parameter  int OFM_RAM_SIZE = 2378675,
   localparam int ADDR_W       = $clog2(OFM_RAM_SIZE)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_layer,
   input  logic [8:0]        ifm_size,
   input  logic [10:0]       ifm_channel,
   input  logic [1:0]        kernel_size,
   input  logic [10:0]       num_filter,
   input  logic              maxpool_mode,
   input  logic [1:0]        maxpool_stride,
   input  logic              upsample_mode,
   input  logic [ADDR_W-1:0] start_read_addr,
   input  logic [ADDR_W-1:0] start_write_addr,
   output logic              done_layer,
   output logic              busy,
   output logic [10:0]       cfg_channel,
   output logic [1:0]        cfg_kernel,
   output logic              cfg_maxpool,
   output logic [1:0]        cfg_stride,
   output logic              cfg_upsample,
`ifdef LAYER_SEQ_CYCLE_CNT_EN
   output logic [31:0]       cycle_count,
`endif
   layer_sequencer_if.master tif
);

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_ISSUE, S_WAIT, S_NEXT, S_DONE
   } state_t;

   state_t            r_state;
   state_t            w_next;

   logic [8:0]        r_ifm_size;
   logic [10:0]       r_num_filter;
   logic [10:0]       r_cfg_channel;
   logic [1:0]        r_kernel;
   logic              r_cfg_maxpool;
   logic [1:0]        r_cfg_stride;
   logic              r_cfg_upsample;
   logic [ADDR_W-1:0] r_rd_base;
   logic [ADDR_W-1:0] r_wr_base;
   logic [8:0]        r_conv_out;
   logic [8:0]        r_row;
   logic [10:0]       r_fbase;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [ADDR_W-1:0] r_wr_ptr;

   logic              w_tile_valid;
   logic              w_done;
   logic              w_empty;
   logic              w_last_row;
   logic              w_last_grp;
   logic              w_last_tile;
   logic [12:0]       w_fb_next;

   assign w_empty    = (r_num_filter == 11'd0) || (r_kernel == 2'd0) ||
                       (r_ifm_size < {7'd0, r_kernel});
   assign w_last_row = (r_row == r_conv_out - 9'd1);
   // Last group is the one whose next base would reach num_filter; avoids a divider for num_groups.
   assign w_fb_next  = {2'b00, r_fbase} + 13'(NUM_PE);
   assign w_last_grp = (w_fb_next >= {2'b00, r_num_filter});
   assign w_last_tile = w_last_row && w_last_grp;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next       = r_state;
      w_tile_valid = 1'b0;
      w_done       = 1'b0;
      case (r_state)
         S_IDLE:  if (start_layer) w_next = S_SETUP;
         S_SETUP: w_next = w_empty ? S_DONE : S_ISSUE;
         S_ISSUE: begin
            w_tile_valid = 1'b1;
            if (tif.tile_ready) w_next = S_WAIT;
         end
         S_WAIT:  if (tif.tile_done) w_next = S_NEXT;
         S_NEXT:  w_next = w_last_tile ? S_DONE : S_ISSUE;
         S_DONE: begin
            w_done = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ifm_size     <= '0;
         r_num_filter   <= '0;
         r_cfg_channel  <= '0;
         r_kernel       <= '0;
         r_cfg_maxpool  <= 1'b0;
         r_cfg_stride   <= '0;
         r_cfg_upsample <= 1'b0;
         r_rd_base      <= '0;
         r_wr_base      <= '0;
         r_conv_out     <= '0;
         r_row          <= '0;
         r_fbase        <= '0;
         r_rd_ptr       <= '0;
         r_wr_ptr       <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start_layer) begin
                  r_ifm_size     <= ifm_size;
                  r_num_filter   <= num_filter;
                  r_cfg_channel  <= ifm_channel;
                  r_kernel       <= kernel_size;
                  r_cfg_maxpool  <= maxpool_mode;
                  r_cfg_stride   <= maxpool_stride;
                  r_cfg_upsample <= upsample_mode;
                  r_rd_base      <= start_read_addr;
                  r_wr_base      <= start_write_addr;
               end
            end
            S_SETUP: begin
               r_conv_out <= r_ifm_size - {7'd0, r_kernel} + 9'd1;
               r_row      <= '0;
               r_fbase    <= '0;
               r_rd_ptr   <= r_rd_base;
               r_wr_ptr   <= r_wr_base;
            end
            S_NEXT: begin
               r_wr_ptr <= r_wr_ptr + ADDR_W'(r_conv_out);
               if (!w_last_row) begin
                  r_row    <= r_row + 9'd1;
                  r_rd_ptr <= r_rd_ptr + ADDR_W'(r_ifm_size);
               end else begin
                  r_row    <= '0;
                  r_rd_ptr <= r_rd_base;
                  r_fbase  <= w_fb_next[10:0];
               end
            end
            default: ;
         endcase
      end
   end

`ifdef LAYER_SEQ_CYCLE_CNT_EN
   logic [31:0] r_cycle_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cycle_cnt <= '0;
      end else if (r_state == S_IDLE && start_layer) begin
         r_cycle_cnt <= '0;
      end else if (r_state != S_IDLE) begin
         r_cycle_cnt <= r_cycle_cnt + 32'd1;
      end
   end

   assign cycle_count = r_cycle_cnt;
`endif

   assign busy         = (r_state != S_IDLE);
   assign done_layer   = w_done;
   assign cfg_channel  = r_cfg_channel;
   assign cfg_kernel   = r_kernel;
   assign cfg_maxpool  = r_cfg_maxpool;
   assign cfg_stride   = r_cfg_stride;
   assign cfg_upsample = r_cfg_upsample;

   assign tif.tile_valid       = w_tile_valid;
   assign tif.tile_rd_addr     = r_rd_ptr;
   assign tif.tile_wr_addr     = r_wr_ptr;
   assign tif.tile_filter_base = r_fbase;
   assign tif.tile_row         = r_row;
   assign tif.tile_last        = w_tile_valid && w_last_tile;

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: table of layer configs with hand-computed tile totals,
// plus stall/noise, mid-layer reset and address-wrap sequences.
module tb_layer_sequencer;
   localparam int ADDR_W = 22;
   localparam int NUM_PE = 16;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start_layer;
   logic [8:0]        ifm_size;
   logic [10:0]       ifm_channel;
   logic [1:0]        kernel_size;
   logic [10:0]       num_filter;
   logic              maxpool_mode;
   logic [1:0]        maxpool_stride;
   logic              upsample_mode;
   logic [ADDR_W-1:0] start_read_addr;
   logic [ADDR_W-1:0] start_write_addr;
   logic              done_layer;
   logic              busy;
   logic [10:0]       cfg_channel;
   logic [1:0]        cfg_kernel;
   logic              cfg_maxpool;
   logic [1:0]        cfg_stride;
   logic              cfg_upsample;
`ifdef LAYER_SEQ_CYCLE_CNT_EN
   logic [31:0]       cycle_count;
`endif

   always #5 clk = ~clk;

   layer_sequencer_if #(.ADDR_W(ADDR_W)) tif();

   layer_sequencer #(.NUM_PE(NUM_PE), .OFM_RAM_SIZE(2378675)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .start_layer      (start_layer),
      .ifm_size         (ifm_size),
      .ifm_channel      (ifm_channel),
      .kernel_size      (kernel_size),
      .num_filter       (num_filter),
      .maxpool_mode     (maxpool_mode),
      .maxpool_stride   (maxpool_stride),
      .upsample_mode    (upsample_mode),
      .start_read_addr  (start_read_addr),
      .start_write_addr (start_write_addr),
      .done_layer       (done_layer),
      .busy             (busy),
      .cfg_channel      (cfg_channel),
      .cfg_kernel       (cfg_kernel),
      .cfg_maxpool      (cfg_maxpool),
      .cfg_stride       (cfg_stride),
      .cfg_upsample     (cfg_upsample),
`ifdef LAYER_SEQ_CYCLE_CNT_EN
      .cycle_count      (cycle_count),
`endif
      .tif              (tif)
   );

   typedef struct {
      logic [8:0]        ifm;
      logic [1:0]        k;
      logic [10:0]       nf;
      logic [ADDR_W-1:0] rd_base;
      logic [ADDR_W-1:0] wr_base;
      logic [10:0]       chan;
      int                exp_tiles;
      logic [ADDR_W-1:0] exp_last_wr;
      logic [10:0]       exp_last_fb;
   } vec_t;

   localparam int NV = 8;
   vec_t vec [NV];

   int n_tests = 0;
   int n_fail  = 0;
   int n_done  = 0;
   int n_busy  = 0;

   always @(negedge clk) begin
      if (done_layer) n_done++;
      if (busy) n_busy++;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_tile(input string tag, input logic [ADDR_W-1:0] e_rd,
                           input logic [ADDR_W-1:0] e_wr, input logic [10:0] e_fb,
                           input int e_row, input bit e_last);
      chk({tag, "_valid"}, tif.tile_valid, 1);
      chk({tag, "_rd"},    tif.tile_rd_addr, e_rd);
      chk({tag, "_wr"},    tif.tile_wr_addr, e_wr);
      chk({tag, "_fb"},    tif.tile_filter_base, e_fb);
      chk({tag, "_row"},   tif.tile_row, e_row);
      chk({tag, "_last"},  tif.tile_last, e_last);
   endtask

   // abort_at > 0 returns while waiting on the engine for that tile number.
   task automatic run_layer(input vec_t v, input int stall, input bit noise, input int abort_at);
      int                groups, co, idx, d0, b0, budget;
      bit                empty, e_last;
      logic [ADDR_W-1:0] e_rd, e_wr, last_wr;
      logic [10:0]       e_fb, last_fb;
      empty   = (v.nf == 0) || (v.k == 0) || (v.ifm < {7'd0, v.k});
      co      = empty ? 0 : int'(v.ifm) - int'(v.k) + 1;
      groups  = empty ? 0 : (int'(v.nf) + NUM_PE - 1) / NUM_PE;
      idx     = 0;
      last_wr = '0;
      last_fb = '0;
      d0      = n_done;

      ifm_size         = v.ifm;
      kernel_size      = v.k;
      num_filter       = v.nf;
      start_read_addr  = v.rd_base;
      start_write_addr = v.wr_base;
      ifm_channel      = v.chan;
      maxpool_stride   = v.chan[1:0];
      maxpool_mode     = v.chan[2];
      upsample_mode    = v.chan[3];
      start_layer      = 1'b1;
      cyc();
      start_layer      = 1'b0;
      b0               = n_busy;
      // Scramble the inputs so only latched values can reach the outputs.
      ifm_size         = '1;
      kernel_size      = 2'd0;
      num_filter       = 11'd0;
      start_read_addr  = '0;
      start_write_addr = '1;
      ifm_channel      = 11'd0;
      maxpool_stride   = ~v.chan[1:0];
      maxpool_mode     = ~v.chan[2];
      upsample_mode    = ~v.chan[3];

      chk("busy_after_start", busy, 1);
      chk("cfg_channel", cfg_channel, v.chan);
      chk("cfg_kernel", cfg_kernel, v.k);
      chk("cfg_stride", cfg_stride, v.chan[1:0]);
      chk("cfg_maxpool", cfg_maxpool, v.chan[2]);
      chk("cfg_upsample", cfg_upsample, v.chan[3]);

      if (empty) begin
         chk("empty_setup_valid", tif.tile_valid, 0);
         chk("empty_setup_done", done_layer, 0);
         cyc();
         // Third cycle of start/SETUP/DONE carries the pulse.
         chk("empty_done", done_layer, 1);
         chk("empty_valid", tif.tile_valid, 0);
      end else begin
         for (int g = 0; g < groups; g++) begin
            for (int r = 0; r < co; r++) begin
               e_rd   = v.rd_base + ADDR_W'(r * int'(v.ifm));
               e_wr   = v.wr_base + ADDR_W'((g * co + r) * co);
               e_fb   = 11'(g * NUM_PE);
               e_last = (g == groups - 1) && (r == co - 1);
               budget = 10;
               while (!tif.tile_valid && budget > 0) begin
                  chk("no_early_done", done_layer, 0);
                  cyc();
                  budget--;
               end
               chk("tile_valid_timeout", tif.tile_valid, 1);
               if (!tif.tile_valid) return;
               chk_tile("tile", e_rd, e_wr, e_fb, r, e_last);
               if (stall > 0) begin
                  tif.tile_ready = 1'b0;
                  for (int s = 0; s < stall; s++) begin
                     if (noise && s == 1) begin
                        tif.tile_done = 1'b1;
                        start_layer   = 1'b1;
                        num_filter    = 11'd5;
                        kernel_size   = 2'd1;
                     end
                     cyc();
                     tif.tile_done = 1'b0;
                     start_layer   = 1'b0;
                     chk_tile("stall", e_rd, e_wr, e_fb, r, e_last);
                  end
                  chk("stall_cfg_kernel", cfg_kernel, v.k);
               end
               tif.tile_ready = 1'b1;
               cyc();
               tif.tile_ready = 1'b0;
               chk("wait_valid_low", tif.tile_valid, 0);
               last_wr = e_wr;
               last_fb = e_fb;
               idx++;
               if (idx == abort_at) return;
               cyc();
               chk("wait_holds", tif.tile_valid, 0);
               tif.tile_done = 1'b1;
               cyc();
               tif.tile_done = 1'b0;
               chk("next_no_done", done_layer, 0);
               chk("next_no_valid", tif.tile_valid, 0);
               cyc();
               if (e_last) chk("done_after_last", done_layer, 1);
               else        chk("no_done_midlayer", done_layer, 0);
            end
         end
      end
      cyc();
      chk("done_one_cycle", done_layer, 0);
      chk("busy_cleared", busy, 0);
      chk("tile_count", idx, v.exp_tiles);
      chk("last_wr", last_wr, v.exp_last_wr);
      chk("last_fb", last_fb, v.exp_last_fb);
      chk("done_pulses", n_done - d0, 1);
`ifdef LAYER_SEQ_CYCLE_CNT_EN
      chk("cycle_count", cycle_count, n_busy - b0);
      repeat (3) cyc();
      chk("cycle_count_hold", cycle_count, n_busy - b0);
`endif
   endtask

   initial begin
      int d;
      //          ifm    k     nf       rd_base        wr_base         chan    tiles last_wr        last_fb
      vec[0] = '{9'd5, 2'd3, 11'd32, 22'd100,     22'd1000,     11'd64, 6, 22'd1015, 11'd16};
      vec[1] = '{9'd3, 2'd1, 11'd17, 22'd0,       22'd0,        11'd3,  6, 22'd15,   11'd16};
      vec[2] = '{9'd5, 2'd3, 11'd0,  22'd10,      22'd20,       11'd5,  0, 22'd0,    11'd0};
      vec[3] = '{9'd5, 2'd0, 11'd20, 22'd10,      22'd20,       11'd9,  0, 22'd0,    11'd0};
      vec[4] = '{9'd2, 2'd3, 11'd8,  22'd10,      22'd20,       11'd14, 0, 22'd0,    11'd0};
      vec[5] = '{9'd5, 2'd3, 11'd32, 22'd4194000, 22'd4194300,  11'd7,  6, 22'd11,   11'd16};
      vec[6] = '{9'd3, 2'd3, 11'd1,  22'd9,       22'd20,       11'd15, 1, 22'd20,   11'd0};
      vec[7] = '{9'd4, 2'd2, 11'd48, 22'd7,       22'd50,       11'd10, 9, 22'd74,   11'd32};

      rst_n            = 1'b0;
      start_layer      = 1'b0;
      ifm_size         = '0;
      ifm_channel      = '0;
      kernel_size      = '0;
      num_filter       = '0;
      maxpool_mode     = 1'b0;
      maxpool_stride   = '0;
      upsample_mode    = 1'b0;
      start_read_addr  = '0;
      start_write_addr = '0;
      tif.tile_ready   = 1'b0;
      tif.tile_done    = 1'b0;

      #3;
      chk("rst_busy", busy, 0);
      chk("rst_done", done_layer, 0);
      chk("rst_valid", tif.tile_valid, 0);
      chk("rst_last", tif.tile_last, 0);
      chk("rst_rd", tif.tile_rd_addr, 0);
      chk("rst_wr", tif.tile_wr_addr, 0);
      chk("rst_cfg_channel", cfg_channel, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc();

      tif.tile_done = 1'b1;
      cyc();
      tif.tile_done = 1'b0;
      cyc();
      chk("idle_tile_done_busy", busy, 0);
      chk("idle_tile_done_valid", tif.tile_valid, 0);

      for (int i = 0; i < NV; i++) run_layer(vec[i], 0, 1'b0, -1);

      run_layer(vec[0], 5, 1'b1, -1);

      run_layer(vec[0], 0, 1'b0, 3);
      d = n_done;
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", tif.tile_valid, 0);
      chk("arst_busy", busy, 0);
      chk("arst_done", done_layer, 0);
      chk("arst_last", tif.tile_last, 0);
      chk("arst_rd", tif.tile_rd_addr, 0);
      chk("arst_wr", tif.tile_wr_addr, 0);
      chk("arst_fb", tif.tile_filter_base, 0);
      chk("arst_row", tif.tile_row, 0);
      chk("arst_cfg_channel", cfg_channel, 0);
      chk("arst_cfg_kernel", cfg_kernel, 0);
      @(posedge clk);
      #1;
      cyc();
      rst_n = 1'b1;
      tif.tile_done = 1'b1;
      cyc();
      tif.tile_done = 1'b0;
      repeat (3) cyc();
      chk("abort_no_done", n_done - d, 0);
      chk("abort_idle", busy, 0);

      run_layer(vec[0], 0, 1'b0, -1);
      run_layer(vec[5], 0, 1'b0, -1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
